// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with true-LRU replacement, flush and hit/mispredict statistics.
// Latency: lookup is combinational on the state as of the last edge; updates take effect at the next edge.
// Backpressure: none; an update is accepted on every cycle that upd_valid is high.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   if_pc                 fetch PC to look up
//   predict_hit/taken     lookup result; taken needs a hit and the counter MSB set
//   predict_target        stored target when predict_taken, else 0
//   upd_valid/pc/taken/   resolved-branch update from EX
//   upd_target/mispredict
//   flush                 invalidate every entry (ranks, counters and statistics are kept)
//   hit_count             saturating count of updates that hit an entry
//   mispredict_count      saturating count of updates flagged as mispredicted
module branch_target_buffer #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              predict_hit,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int RANK_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_WEAK  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [RANK_W-1:0] RANK_LAST = RANK_W'(ENTRIES - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    // Entry storage
    logic [ENTRIES-1:0] r_valid;
    logic [ADDR_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];
    logic [RANK_W-1:0]  r_rank   [ENTRIES];

    logic [STAT_W-1:0]  r_hit_count;
    logic [STAT_W-1:0]  r_mp_count;

    // Fetch-side lookup
    logic               w_lk_hit;
    logic [RANK_W-1:0]  w_lk_idx;
    logic               w_lk_taken;

    // Update-side lookup and replacement
    logic               w_up_hit;
    logic [RANK_W-1:0]  w_up_idx;
    logic               w_any_free;
    logic [RANK_W-1:0]  w_free_idx;
    logic [RANK_W-1:0]  w_lru_idx;
    logic [RANK_W-1:0]  w_victim_idx;
    logic               w_touch_en;
    logic [RANK_W-1:0]  w_touch_idx;
    logic [RANK_W-1:0]  w_touch_rank;
    logic [CNT_W-1:0]   w_cnt_cur;
    logic [CNT_W-1:0]   w_cnt_next;

    // Scanning from the top down lets the lowest matching index win without
    // reading the partial result back inside the loop.
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == if_pc)) begin
                w_lk_hit = 1'b1;
                w_lk_idx = RANK_W'(i);
            end
        end
    end

    assign w_lk_taken     = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
    assign predict_hit    = w_lk_hit;
    assign predict_taken  = w_lk_taken;
    assign predict_target = w_lk_taken ? r_target[w_lk_idx] : '0;

    always_comb begin
        w_up_hit   = 1'b0;
        w_up_idx   = '0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_lru_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == upd_pc)) begin
                w_up_hit = 1'b1;
                w_up_idx = RANK_W'(i);
            end
            if (!r_valid[i]) begin
                w_any_free = 1'b1;
                w_free_idx = RANK_W'(i);
            end
            // Ranks are a permutation, so exactly one entry holds the last rank.
            if (r_rank[i] == RANK_LAST) begin
                w_lru_idx = RANK_W'(i);
            end
        end
    end

    assign w_victim_idx = w_any_free ? w_free_idx : w_lru_idx;

    // Only a hit or a taken miss (allocation) touches the LRU order.
    assign w_touch_en   = upd_valid && (w_up_hit || upd_taken);
    assign w_touch_idx  = w_up_hit ? w_up_idx : w_victim_idx;
    assign w_touch_rank = r_rank[w_touch_idx];

    // Saturation is checked before stepping so the counter never wraps.
    assign w_cnt_cur = r_cnt[w_up_idx];
    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (upd_taken) begin
            if (w_cnt_cur != CNT_MAX) begin
                w_cnt_next = w_cnt_cur + 1'b1;
            end
        end else begin
            if (w_cnt_cur != '0) begin
                w_cnt_next = w_cnt_cur - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid     <= '0;
            r_hit_count <= '0;
            r_mp_count  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= '0;
                r_rank[i]   <= RANK_W'(i);
            end
        end else if (flush) begin
            // A same-cycle update, including its statistics, is dropped.
            r_valid <= '0;
        end else if (upd_valid) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= w_cnt_next;
                if (upd_taken) begin
                    r_target[w_up_idx] <= upd_target;
                end
                if (r_hit_count != STAT_MAX) begin
                    r_hit_count <= r_hit_count + 1'b1;
                end
            end else if (upd_taken) begin
                r_valid[w_victim_idx]  <= 1'b1;
                r_tag[w_victim_idx]    <= upd_pc;
                r_target[w_victim_idx] <= upd_target;
                r_cnt[w_victim_idx]    <= CNT_WEAK;
            end

            if (w_touch_en) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (RANK_W'(i) == w_touch_idx) begin
                        r_rank[i] <= '0;
                    end else if (r_rank[i] < w_touch_rank) begin
                        r_rank[i] <= r_rank[i] + 1'b1;
                    end
                end
            end

            if (upd_mispredict && (r_mp_count != STAT_MAX)) begin
                r_mp_count <= r_mp_count + 1'b1;
            end
        end
    end

    assign hit_count        = r_hit_count;
    assign mispredict_count = r_mp_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: default-configuration BTB (A) plus a 2-entry, 4-bit-statistics BTB (B) on shared inputs.
// Latency: lookups are compared on the falling edge of the cycle they are driven.
// Backpressure: none; stimulus is driven one cycle at a time.
module tb_branch_target_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush;

    logic        a_hit, a_tk;
    logic [31:0] a_tgt;
    logic [15:0] a_hcnt, a_mcnt;
    logic        b_hit, b_tk;
    logic [31:0] b_tgt;
    logic [3:0]  b_hcnt, b_mcnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          sel;
        string       tag;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t sbq[$];

    always #5 clock = ~clock;

    branch_target_buffer dut_a (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .predict_hit(a_hit), .predict_taken(a_tk), .predict_target(a_tgt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
        .hit_count(a_hcnt), .mispredict_count(a_mcnt)
    );

    branch_target_buffer #(.ENTRIES(2), .ADDR_W(32), .CNT_W(2), .STAT_W(4)) dut_b (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .predict_hit(b_hit), .predict_taken(b_tk), .predict_target(b_tgt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
        .hit_count(b_hcnt), .mispredict_count(b_mcnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Drive if_pc and push the expected prediction for the selected instance.
    task automatic expect_pred(input bit sel, input string tag, input logic [31:0] pc,
                               input logic h, input logic t, input logic [31:0] tg);
        exp_t e;
        if_pc = pc;
        e.sel = sel; e.tag = tag; e.hit = h; e.tk = t; e.tgt = tg;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (!e.sel) begin
                chk({e.tag, ".hit"}, 32'(a_hit), 32'(e.hit));
                chk({e.tag, ".tk"},  32'(a_tk),  32'(e.tk));
                chk({e.tag, ".tgt"}, a_tgt,      e.tgt);
            end else begin
                chk({e.tag, ".hit"}, 32'(b_hit), 32'(e.hit));
                chk({e.tag, ".tk"},  32'(b_tk),  32'(e.tk));
                chk({e.tag, ".tgt"}, b_tgt,      e.tgt);
            end
        end
    endtask

    // One cycle: drive, compare on the falling edge, return just after the next rising edge.
    task automatic look(input bit sel, input string tag, input logic [31:0] pc,
                        input logic h, input logic t, input logic [31:0] tg);
        expect_pred(sel, tag, pc, h, t, tg);
        @(negedge clock);
        drain();
        @(posedge clock); #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
        @(posedge clock); #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    // Reset with a simultaneous update that must be discarded.
    task automatic reset_with_upd(input logic [31:0] pc);
        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = 1'b1; upd_target = pc + 32'h1000; upd_mispredict = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    initial begin
        reset = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        look(0, "rst_40", 32'h40, 0, 0, 32'h0);
        look(0, "rst_0",  32'h0,  0, 0, 32'h0);
        chk("rst_hcnt", 32'(a_hcnt), 32'd0);
        chk("rst_mcnt", 32'(a_mcnt), 32'd0);

        // Allocation, counter walk and saturation
        upd(32'h40, 1, 32'h80, 0);
        look(0, "alloc_40", 32'h40, 1, 1, 32'h80);
        upd(32'h40, 0, 32'hdead, 0);
        upd(32'h40, 0, 32'hdead, 0);
        look(0, "cnt0", 32'h40, 1, 0, 32'h0);
        for (int i = 0; i < 4; i++) upd(32'h40, 1, 32'h80, 0);
        look(0, "cnt_sat", 32'h40, 1, 1, 32'h80);
        upd(32'h40, 0, 32'h0, 0);
        look(0, "sat_dn1", 32'h40, 1, 1, 32'h80);
        upd(32'h40, 0, 32'h0, 0);
        look(0, "sat_dn2", 32'h40, 1, 0, 32'h0);
        chk("walk_hcnt", 32'(a_hcnt), 32'd8);

        // LRU eviction with 8 entries
        reset = 1'b1; @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 8; i++) upd(32'h100 + 32'(4 * i), 1, 32'h1100 + 32'(4 * i), 0);
        upd(32'h100, 1, 32'h1100, 0);
        upd(32'h200, 1, 32'h1200, 0);
        look(0, "evict_104", 32'h104, 0, 0, 32'h0);
        look(0, "keep_100",  32'h100, 1, 1, 32'h1100);
        look(0, "new_200",   32'h200, 1, 1, 32'h1200);
        look(0, "keep_108",  32'h108, 1, 1, 32'h1108);
        chk("lru_hcnt", 32'(a_hcnt), 32'd1);

        // No bypass from a same-cycle update
        upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h3300;
        expect_pred(0, "byp_same", 32'h300, 0, 0, 32'h0);
        @(negedge clock);
        drain();
        @(posedge clock); #1;
        upd_valid = 1'b0;
        look(0, "byp_next", 32'h300, 1, 1, 32'h3300);
        upd(32'h304, 0, 32'h3304, 0);
        look(0, "nt_miss", 32'h304, 0, 0, 32'h0);

        // Flush beats a same-cycle update
        flush = 1'b1;
        upd(32'h400, 1, 32'h4400, 1);
        flush = 1'b0;
        look(0, "fl_100", 32'h100, 0, 0, 32'h0);
        look(0, "fl_200", 32'h200, 0, 0, 32'h0);
        look(0, "fl_300", 32'h300, 0, 0, 32'h0);
        look(0, "fl_400", 32'h400, 0, 0, 32'h0);
        chk("fl_hcnt", 32'(a_hcnt), 32'd1);
        chk("fl_mcnt", 32'(a_mcnt), 32'd0);
        upd(32'h500, 1, 32'h5500, 0);
        look(0, "fl_realloc", 32'h500, 1, 1, 32'h5500);

        // Statistics saturation on the 4-bit instance, then reset mid-sequence
        reset = 1'b1; @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) upd(32'h600, 1, 32'h6600, 1);
        chk("b_mcnt_sat", 32'(b_mcnt), 32'd15);
        chk("b_hcnt_sat", 32'(b_hcnt), 32'd15);
        chk("a_mcnt20",   32'(a_mcnt), 32'd20);
        chk("a_hcnt19",   32'(a_hcnt), 32'd19);
        look(1, "b_600", 32'h600, 1, 1, 32'h6600);
        reset_with_upd(32'h640);
        chk("b_mcnt_rst", 32'(b_mcnt), 32'd0);
        chk("b_hcnt_rst", 32'(b_hcnt), 32'd0);
        look(1, "b_rst_600", 32'h600, 0, 0, 32'h0);
        look(1, "b_rst_640", 32'h640, 0, 0, 32'h0);

        // Two-entry LRU (1-bit rank)
        upd(32'hA0, 1, 32'h10A0, 0);
        upd(32'hA4, 1, 32'h10A4, 0);
        upd(32'hA0, 1, 32'h10A0, 0);
        upd(32'hA8, 1, 32'h10A8, 0);
        look(1, "b_evict_a4", 32'hA4, 0, 0, 32'h0);
        look(1, "b_keep_a0",  32'hA0, 1, 1, 32'h10A0);
        look(1, "b_new_a8",   32'hA8, 1, 1, 32'h10A8);
        chk("b_lru_hcnt", 32'(b_hcnt), 32'd1);

        // Mispredicts counted on a non-allocating miss
        for (int i = 0; i < 3; i++) upd(32'h700, 0, 32'h0, 1);
        chk("b_mcnt_miss", 32'(b_mcnt), 32'd3);
        chk("a_mcnt_miss", 32'(a_mcnt), 32'd3);
        look(1, "b_700", 32'h700, 0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
